// File: rtl/kbd_pkg.sv
// Shared scan code set 2 constants, decoder states and PS/2 frame helpers
// for the keyboard controller.
package kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;

  // Index of the stop bit: the frame is checked on this falling edge.
  localparam logic [3:0] LAST_BIT = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  // Frame layout: [0]=start, [8:1]=d0..d7, [9]=odd parity, [10]=stop.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the pins, shifts in 11-bit frames on
// ps2Clk falling edges and strobes a good byte or a frame error.
module ps2_frame_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_byte_vld,
  output logic [7:0] o_byte_dat,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_prev;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_to_cnt;
  logic          r_byte_vld;
  logic [7:0]    r_byte_dat;
  logic          r_frame_err;

  logic          w_fall;
  logic          w_timeout;
  logic [10:0]   w_frame;

  // Synchronisers idle high so reset release on an idle line is not an edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_sync[1];
  assign w_frame   = {r_dat_sync[1], r_shift};
  assign w_timeout = (r_bit_cnt != 4'd0) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_bit_cnt   <= 4'd0;
      r_shift     <= 10'd0;
      r_to_cnt    <= '0;
      r_byte_vld  <= 1'b0;
      r_byte_dat  <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == LAST_BIT) begin
          r_bit_cnt <= 4'd0;
          if (frame_ok(w_frame)) begin
            r_byte_vld <= 1'b1;
            r_byte_dat <= r_shift[8:1];
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_shift   <= {r_dat_sync[1], r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        // A stalled partial frame is dropped silently.
        if (w_timeout) begin
          r_bit_cnt <= 4'd0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_byte_vld  = r_byte_vld;
  assign o_byte_dat  = r_byte_dat;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/keyboard_controller.sv
// PS/2 keyboard front end: decodes make/break and E0-extended scan codes into
// held levels for the arrows and space, plus a space press pulse.
module keyboard_controller
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       rightArrow,
  output logic       leftArrow,
  output logic       spaceBar,
  output logic       spacePulse,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       frameError
);

  logic       w_byte_vld;
  logic [7:0] w_byte_dat;
  logic       w_frame_err;

  dec_state_t r_state;
  dec_state_t w_state_nxt;
  logic       r_right;
  logic       r_left;
  logic       r_space;
  logic       r_space_pulse;
  logic       w_right_nxt;
  logic       w_left_nxt;
  logic       w_space_nxt;
  logic       w_space_pulse_nxt;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .resetN     (resetN),
    .i_ps2_clk  (ps2Clk),
    .i_ps2_dat  (ps2Data),
    .o_byte_vld (w_byte_vld),
    .o_byte_dat (w_byte_dat),
    .o_frame_err(w_frame_err)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= ST_IDLE;
      r_right       <= 1'b0;
      r_left        <= 1'b0;
      r_space       <= 1'b0;
      r_space_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_right       <= w_right_nxt;
      r_left        <= w_left_nxt;
      r_space       <= w_space_nxt;
      r_space_pulse <= w_space_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_right_nxt       = r_right;
    w_left_nxt        = r_left;
    w_space_nxt       = r_space;
    w_space_pulse_nxt = 1'b0;
    if (w_frame_err) begin
      // Key levels survive a corrupted frame; only the prefix context is lost.
      w_state_nxt = ST_IDLE;
    end else if (w_byte_vld) begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte_dat == SC_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (w_byte_dat == SC_BRK) begin
            w_state_nxt = ST_BRK;
          end else if (w_byte_dat == SC_SPACE) begin
            w_space_nxt       = 1'b1;
            w_space_pulse_nxt = ~r_space;
          end
        end
        ST_EXT: begin
          w_state_nxt = ST_IDLE;
          if (w_byte_dat == SC_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (w_byte_dat == SC_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (w_byte_dat == SC_RIGHT) begin
            w_right_nxt = 1'b1;
          end else if (w_byte_dat == SC_LEFT) begin
            w_left_nxt = 1'b1;
          end
        end
        ST_BRK: begin
          w_state_nxt = ST_IDLE;
          if (w_byte_dat == SC_SPACE) begin
            w_space_nxt = 1'b0;
          end
        end
        ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          if (w_byte_dat == SC_RIGHT) begin
            w_right_nxt = 1'b0;
          end else if (w_byte_dat == SC_LEFT) begin
            w_left_nxt = 1'b0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign rightArrow = r_right;
  assign leftArrow  = r_left;
  assign spaceBar   = r_space;
  assign spacePulse = r_space_pulse;
  assign byteValid  = w_byte_vld;
  assign byteData   = w_byte_dat;
  assign frameError = w_frame_err;

endmodule

// File: tb/tb_keyboard_controller.sv
// Bench for keyboard_controller: directed and random PS/2 traffic checked
// every cycle against a behavioural model of the line, frame and key rules.
module tb_keyboard_controller;

  localparam int TO   = 100;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       rightArrow, leftArrow, spaceBar, spacePulse;
  logic       byteValid, frameError;
  logic [7:0] byteData;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int fe_cnt = 0;
  bit cmp_on = 0;
  bit done = 0;

  always #5 clk = ~clk;

  keyboard_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .rightArrow(rightArrow),
    .leftArrow (leftArrow),
    .spaceBar  (spaceBar),
    .spacePulse(spacePulse),
    .byteValid (byteValid),
    .byteData  (byteData),
    .frameError(frameError)
  );

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  int         mcnt = 0;
  int         last_fall = 0;
  logic [10:0] m_frame = '0;
  logic       m_prev_clk = 1'b1;
  logic       pf_vld = 0, pf_good = 0;
  int         pf_cyc = 0;
  logic [7:0] pf_byte = 0;
  logic       pd_vld = 0, pd_good = 0;
  int         pd_cyc = 0;
  logic [7:0] pd_byte = 0;
  logic       m_ext = 0, m_brk = 0;
  logic       exp_bv = 0, exp_fe = 0, exp_sp = 0, exp_r = 0, exp_l = 0, exp_s = 0;
  logic [7:0] exp_dat = 0;

  initial forever begin
    @(posedge clk or negedge resetN);
    if (!resetN) begin
      mcnt = 0; m_frame = '0; m_prev_clk = 1'b1;
      pf_vld = 0; pd_vld = 0; m_ext = 0; m_brk = 0;
      exp_bv = 0; exp_fe = 0; exp_sp = 0; exp_r = 0; exp_l = 0; exp_s = 0;
      exp_dat = 8'h00;
    end else begin
      cyc++;
      exp_bv = 0; exp_fe = 0; exp_sp = 0;
      if (pd_vld && pd_cyc == cyc) begin
        pd_vld = 0;
        if (!pd_good) begin
          m_ext = 0; m_brk = 0;
        end else if (m_brk) begin
          if (m_ext) begin
            if (pd_byte == 8'h74) exp_r = 0;
            if (pd_byte == 8'h6B) exp_l = 0;
          end else if (pd_byte == 8'h29) exp_s = 0;
          m_ext = 0; m_brk = 0;
        end else if (pd_byte == 8'hF0) m_brk = 1;
        else if (pd_byte == 8'hE0) m_ext = 1;
        else if (m_ext) begin
          if (pd_byte == 8'h74) exp_r = 1;
          if (pd_byte == 8'h6B) exp_l = 1;
          m_ext = 0;
        end else if (pd_byte == 8'h29) begin
          exp_sp = !exp_s;
          exp_s  = 1;
        end
      end
      if (pf_vld && pf_cyc == cyc) begin
        pf_vld = 0;
        if (pf_good) begin exp_bv = 1; exp_dat = pf_byte; end
        else exp_fe = 1;
        pd_vld = 1; pd_cyc = cyc + 1; pd_good = pf_good; pd_byte = pf_byte;
      end
      // Pin edge seen here reaches the outputs two more edges later.
      if (m_prev_clk && !ps2Clk) begin
        if (mcnt != 0 && cyc - last_fall >= TO) mcnt = 0;
        m_frame[mcnt] = ps2Data;
        mcnt++;
        last_fall = cyc;
        if (mcnt == 11) begin
          pf_vld  = 1;
          pf_cyc  = cyc + 2;
          pf_good = (m_frame[0] == 0) && (m_frame[10] == 1) &&
                    ($countones(m_frame[9:1]) % 2 == 1);
          pf_byte = m_frame[8:1];
          mcnt = 0;
        end
      end
      m_prev_clk = ps2Clk;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ~(^b) ^ bad;
    f[10]  = 1'b1;
    return f;
  endfunction

  task automatic send_bit(input logic b);
    ps2Data = b;
    wait_cyc(HALF);
    ps2Clk = 1'b0;
    wait_cyc(HALF);
    ps2Clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int j = lo; j <= hi; j++) send_bit(f[j]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    send_bits(mk_frame(b, bad), 0, 10);
    ps2Data = 1'b1;
    wait_cyc(30);
  endtask

  // ---------------- stimulus and checking ----------------
  initial begin
    fork
      begin
        wait_cyc(2);
        cmp_on = 1;
        wait_cyc(2);
        chk("reset_byteData", byteData, 8'h00);
        chk("reset_space", {7'd0, spaceBar}, 8'd0);
        resetN = 1'b1;
        wait_cyc(5);

        send_frame(8'h29, 1'b0);
        chk("lit_data_29", byteData, 8'h29);
        chk("lit_space_set", {7'd0, spaceBar}, 8'd1);
        chk("lit_pulse_once", pulse_cnt[7:0], 8'd1);

        send_frame(8'h29, 1'b0);
        send_frame(8'h29, 1'b0);
        chk("lit_typematic_nopulse", pulse_cnt[7:0], 8'd1);
        chk("lit_space_held", {7'd0, spaceBar}, 8'd1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        chk("lit_space_break", {7'd0, spaceBar}, 8'd0);

        send_frame(8'hE0, 1'b0); send_frame(8'h74, 1'b0);
        chk("lit_right_set", {7'd0, rightArrow}, 8'd1);
        send_frame(8'hE0, 1'b0); send_frame(8'h6B, 1'b0);
        chk("lit_left_set", {7'd0, leftArrow}, 8'd1);
        send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h74, 1'b0);
        chk("lit_right_break", {7'd0, rightArrow}, 8'd0);
        chk("lit_left_kept", {7'd0, leftArrow}, 8'd1);

        send_frame(8'h29, 1'b1);
        chk("lit_parity_err", fe_cnt[7:0], 8'd1);
        chk("lit_parity_nospace", {7'd0, spaceBar}, 8'd0);
        send_frame(8'hE0, 1'b0); send_frame(8'h55, 1'b1); send_frame(8'h74, 1'b0);
        chk("lit_prefix_lost", {7'd0, rightArrow}, 8'd0);
        chk("lit_err_count2", fe_cnt[7:0], 8'd2);
        send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h6B, 1'b0);
        chk("lit_left_break", {7'd0, leftArrow}, 8'd0);

        send_bits(mk_frame(8'h29, 1'b0), 0, 4);
        wait_cyc(TO + 10);
        send_frame(8'h29, 1'b0);
        chk("lit_timeout_space", {7'd0, spaceBar}, 8'd1);
        chk("lit_timeout_noerr", fe_cnt[7:0], 8'd2);
        send_frame(8'hF0, 1'b0); send_frame(8'h29, 1'b0);

        send_frame(8'hE0, 1'b0); send_frame(8'h74, 1'b0);
        chk("lit_right_before_rst", {7'd0, rightArrow}, 8'd1);
        send_bits(mk_frame(8'h74, 1'b0), 0, 4);
        #1 resetN = 1'b0;
        #1;
        chk("lit_rst_right", {7'd0, rightArrow}, 8'd0);
        chk("lit_rst_byteData", byteData, 8'h00);
        wait_cyc(5);
        resetN = 1'b1;
        send_bits(mk_frame(8'h74, 1'b0), 5, 10);
        ps2Data = 1'b1;
        wait_cyc(TO + 50);
        chk("lit_misaligned_noright", {7'd0, rightArrow}, 8'd0);
        send_frame(8'h29, 1'b0);
        chk("lit_after_rst_space", {7'd0, spaceBar}, 8'd1);
        chk("lit_after_rst_pulses", pulse_cnt[7:0], 8'd3);

        for (int i = 0; i < 120; i++) begin
          int sel;
          int k;
          logic [7:0] bv;
          sel = $urandom_range(0, 19);
          case (sel)
            0, 1, 2:  bv = 8'hE0;
            3, 4, 5:  bv = 8'hF0;
            6, 7, 8:  bv = 8'h29;
            9, 10:    bv = 8'h74;
            11, 12:   bv = 8'h6B;
            default:  bv = 8'($urandom);
          endcase
          if (sel == 19) begin
            k = $urandom_range(1, 9);
            send_bits(11'($urandom), 0, k - 1);
            ps2Data = 1'b1;
            wait_cyc(TO + 20);
          end else begin
            send_frame(bv, $urandom_range(0, 11) == 0);
          end
        end
        wait_cyc(20);
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (spacePulse) pulse_cnt++;
          if (frameError) fe_cnt++;
          if (cmp_on && !done) begin
            chk("byteValid", {7'd0, byteValid}, {7'd0, exp_bv});
            chk("frameError", {7'd0, frameError}, {7'd0, exp_fe});
            chk("byteData", byteData, exp_dat);
            chk("spacePulse", {7'd0, spacePulse}, {7'd0, exp_sp});
            chk("spaceBar", {7'd0, spaceBar}, {7'd0, exp_s});
            chk("rightArrow", {7'd0, rightArrow}, {7'd0, exp_r});
            chk("leftArrow", {7'd0, leftArrow}, {7'd0, exp_l});
          end
        end
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
